// File: rtl/reset_sequencer_if.sv
// Reset sequencer bus: PLL lock and software request in, staged resets out.
// Optional watchdog signals exist only when RST_WATCHDOG_EN is defined.
interface reset_sequencer_if #(
  parameter int N_CH = 4
);
  logic            clk_locked;
  logic            sw_rst_req;
  logic [N_CH-1:0] rst_out;
  logic [N_CH-1:0] n_rst_out;
  logic            rst_done;
`ifdef RST_WATCHDOG_EN
  logic            wdt_kick;
  logic            wdt_flag;

  modport master (
    output clk_locked, sw_rst_req, wdt_kick,
    input  rst_out, n_rst_out, rst_done, wdt_flag
  );
  modport slave (
    input  clk_locked, sw_rst_req, wdt_kick,
    output rst_out, n_rst_out, rst_done, wdt_flag
  );
`else
  modport master (
    output clk_locked, sw_rst_req,
    input  rst_out, n_rst_out, rst_done
  );
  modport slave (
    input  clk_locked, sw_rst_req,
    output rst_out, n_rst_out, rst_done
  );
`endif
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: filters PLL lock, holds all channels in reset,
// then releases them one by one, lowest index first. Lock loss or a
// software request re-asserts every channel. All outputs are registered.
// Optional macro RST_WATCHDOG_EN adds a RUN-state watchdog (wdt_kick/wdt_flag).
module reset_sequencer #(
  parameter int N_CH        = 4,
  parameter int LOCK_FILTER = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int CNT_W       = 8,
  parameter int WDT_CYCLES  = 1024
) (
  input  logic             clk_in,
  input  logic             rst_in,
  reset_sequencer_if.slave bus
);

  localparam int MAX_LH  = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
  localparam int MAX_CNT = (MAX_LH > STAGE_GAP) ? MAX_LH : STAGE_GAP;
  localparam int IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Parameter sanity: the shared counter must hold the largest terminal count
  if ((MAX_CNT >> CNT_W) != 0) begin : g_cnt_w_too_small
    $error("reset_sequencer: CNT_W too small for LOCK_FILTER/HOLD_CYCLES/STAGE_GAP");
  end
  if (N_CH < 1 || LOCK_FILTER < 1 || HOLD_CYCLES < 1 || STAGE_GAP < 1 || WDT_CYCLES < 1)
  begin : g_param_range
    $error("reset_sequencer: parameters must all be >= 1");
  end

  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RELEASE, RUN} state_t;

  state_t          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [N_CH-1:0] rst_out_q;
  logic [N_CH-1:0] n_rst_out_q;
  logic            rst_done_q;
  logic            lock_meta_q;
  logic            lock_s_q;
  logic            abort_req;

`ifdef RST_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_cnt_q;
  logic             wdt_flag_q;
  logic             wdt_fire;

  // The watchdog only bites in RUN, on the edge where the count would reach WDT_CYCLES
  assign wdt_fire  = (state_q == RUN) && !bus.wdt_kick &&
                     (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1));
  assign abort_req = bus.sw_rst_req | wdt_fire;

  // Watchdog counter runs only in RUN; any kick, abort or state exit clears it
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wdt_cnt_q  <= '0;
      wdt_flag_q <= 1'b0;
    end else begin
      if (state_q != RUN || !lock_s_q || bus.sw_rst_req || bus.wdt_kick || wdt_fire)
        wdt_cnt_q <= '0;
      else
        wdt_cnt_q <= wdt_cnt_q + 1'b1;
      if (lock_s_q && wdt_fire)
        wdt_flag_q <= 1'b1;
    end
  end

  assign bus.wdt_flag = wdt_flag_q;
`else
  assign abort_req = bus.sw_rst_req;
`endif

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= bus.clk_locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Sequencer FSM with registered reset outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      idx_q       <= '0;
      rst_out_q   <= '1;
      n_rst_out_q <= '0;
      rst_done_q  <= 1'b0;
    end else if (state_q == WAIT_LOCK) begin
      // Software requests are ignored until lock has been accepted
      if (!lock_s_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(LOCK_FILTER - 1)) begin
        state_q <= HOLD;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (!lock_s_q) begin
      // Lock loss beats everything else and forces a fresh lock filter
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      idx_q       <= '0;
      rst_out_q   <= '1;
      n_rst_out_q <= '0;
      rst_done_q  <= 1'b0;
    end else if (abort_req) begin
      // Re-enter (or restart) HOLD without re-filtering lock
      state_q     <= HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      rst_out_q   <= '1;
      n_rst_out_q <= '0;
      rst_done_q  <= 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            cnt_q          <= '0;
            rst_out_q[0]   <= 1'b0;
            n_rst_out_q[0] <= 1'b1;
            if (N_CH == 1) begin
              state_q    <= RUN;
              rst_done_q <= 1'b1;
            end else begin
              state_q <= RELEASE;
              idx_q   <= IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
            cnt_q              <= '0;
            rst_out_q[idx_q]   <= 1'b0;
            n_rst_out_q[idx_q] <= 1'b1;
            if (idx_q == IDX_W'(N_CH - 1)) begin
              state_q    <= RUN;
              rst_done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          // RUN: hold everything released until an abort
        end
      endcase
    end
  end

  assign bus.rst_out   = rst_out_q;
  assign bus.n_rst_out = n_rst_out_q;
  assign bus.rst_done  = rst_done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer. Stimulus pushes the model's
// expected outputs into a queue; a negedge monitor pops and compares.
// Build with RST_WATCHDOG_EN defined to also exercise the watchdog.
module tb_reset_sequencer;

  localparam int N_CH = 4;
  localparam int LF   = 4;
  localparam int HOLD = 16;
  localparam int GAP  = 8;
  localparam int WDT  = 32;
`ifdef RST_WATCHDOG_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reset_sequencer_if #(.N_CH(N_CH)) seq_if ();

  reset_sequencer #(
    .N_CH(N_CH), .LOCK_FILTER(LF), .HOLD_CYCLES(HOLD),
    .STAGE_GAP(GAP), .CNT_W(8), .WDT_CYCLES(WDT)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(seq_if)
  );

  typedef struct {
    logic [N_CH-1:0] rst;
    logic            done;
    logic            wflag;
  } exp_t;

  exp_t exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: edge counter, lock acceptance and a hold-start edge.
  // Channel k is released HOLD + k*GAP edges after the hold start.
  int m_n, m_s1, m_s2, m_run, m_base, m_wref;
  bit m_acc, m_wflag;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_n = 0; m_s1 = 0; m_s2 = 0; m_run = 0; m_base = 0; m_wref = 0;
    m_acc = 1'b0; m_wflag = 1'b0;
  endfunction

  function automatic int rel_at(input int e);
    int r;
    if (!m_acc || (e - m_base) < HOLD) return 0;
    r = (e - m_base - HOLD) / GAP + 1;
    return (r > N_CH) ? N_CH : r;
  endfunction

  function automatic void model_step(input bit lock, input bit sw, input bit kick);
    bit lock_s, was_acc, was_run, fire;
    m_n++;
    lock_s  = (m_s2 != 0);
    m_s2    = m_s1;
    m_s1    = lock ? 1 : 0;
    was_acc = m_acc;
    was_run = m_acc && (rel_at(m_n - 1) == N_CH);
    fire    = 1'b0;
    if (!lock_s) begin
      m_acc = 1'b0;
      m_run = 0;
    end else if (!was_acc) begin
      m_run++;
      if (m_run == LF) begin
        m_acc  = 1'b1;
        m_base = m_n;
      end
    end else begin
      if (WDT_ON && was_run) begin
        if (kick) m_wref = m_n;
        else if (m_n - m_wref == WDT) fire = 1'b1;
      end
      if (fire) m_wflag = 1'b1;
      if (sw || fire) m_base = m_n;
    end
    if (m_acc && rel_at(m_n) == N_CH && !was_run) m_wref = m_n;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int rel;
    rel = rel_at(m_n);
    for (int k = 0; k < N_CH; k++) e.rst[k] = !(m_acc && k < rel);
    e.done  = m_acc && (rel == N_CH);
    e.wflag = m_wflag;
    return e;
  endfunction

  // One clock of stimulus; expected outputs after the edge go to the scoreboard
  task automatic cycle(input bit lock, input bit sw, input bit kick);
    seq_if.clk_locked = lock;
    seq_if.sw_rst_req = sw;
`ifdef RST_WATCHDOG_EN
    seq_if.wdt_kick = kick;
`endif
    @(posedge clk);
    model_step(lock, sw, kick);
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  // Asynchronous reset: outputs must change with no clock edge
  task automatic do_reset();
    logic [N_CH-1:0] ones;
    ones = '1;
    #2;
    rst = 1'b1;
    #1;
    check("async rst_out", seq_if.rst_out, ones);
    check("async n_rst_out", seq_if.n_rst_out, 0);
    check("async rst_done", seq_if.rst_done, 0);
`ifdef RST_WATCHDOG_EN
    check("async wdt_flag", seq_if.wdt_flag, 0);
`endif
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Scoreboard monitor
  exp_t mon_e;
  logic [N_CH-1:0] mon_nr;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nr = ~mon_e.rst;
      check("rst_out", seq_if.rst_out, mon_e.rst);
      check("n_rst_out", seq_if.n_rst_out, mon_nr);
      check("rst_done", seq_if.rst_done, mon_e.done);
`ifdef RST_WATCHDOG_EN
      check("wdt_flag", seq_if.wdt_flag, mon_e.wflag);
`endif
    end
  end

  initial begin
    int rel_edge[N_CH];
    logic [N_CH-1:0] want;
    int lock_low, sw_hold;
    bit l, s, kk;
    rel_edge = '{22, 30, 38, 46};
    seq_if.clk_locked = 1'b0;
    seq_if.sw_rst_req = 1'b0;
`ifdef RST_WATCHDOG_EN
    seq_if.wdt_kick = 1'b0;
`endif
    model_reset();

    // 1: steady lock, release edges from a fixed table
    do_reset();
    for (int k = 1; k <= 60; k++) begin
      cycle(1'b1, 1'b0, 1'b0);
      for (int j = 0; j < N_CH; j++) want[j] = (k < rel_edge[j]);
      check("table rst_out", seq_if.rst_out, want);
      check("table rst_done", seq_if.rst_done, (k >= rel_edge[N_CH-1]) ? 1 : 0);
    end
    $display("[TB] phase 1 steady-lock sequence done, %0d tests", tests_run);

    // 2: one-cycle lock glitch during filtering
    do_reset();
    for (int k = 1; k <= 60; k++) cycle(k != 4, 1'b0, 1'b0);
    $display("[TB] phase 2 lock glitch done, %0d tests", tests_run);

    // 3: lock drop in RUN, then recovery
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    repeat (70) cycle(1'b1, 1'b0, 1'b0);
    $display("[TB] phase 3 lock loss in RUN done, %0d tests", tests_run);

    // 4: software pulse in RUN
    cycle(1'b1, 1'b1, 1'b0);
    repeat (60) cycle(1'b1, 1'b0, 1'b0);
    $display("[TB] phase 4 sw request in RUN done, %0d tests", tests_run);

    // 5: lock loss and sw request seen together in RELEASE, then reset mid-RELEASE
    do_reset();
    repeat (28) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (40) cycle(1'b1, 1'b0, 1'b0);
    do_reset();
    repeat (30) cycle(1'b1, 1'b0, 1'b0);
    do_reset();
    $display("[TB] phase 5 combined abort and async reset done, %0d tests", tests_run);

    // 6: randomised lock dropouts, sw requests (pulse or level) and kicks
    lock_low = 0;
    sw_hold  = 0;
    for (int i = 0; i < 3000; i++) begin
      if (lock_low == 0 && $urandom_range(0, 199) == 0) lock_low = $urandom_range(1, 4);
      l = (lock_low == 0);
      if (lock_low > 0) lock_low--;
      if (sw_hold == 0 && $urandom_range(0, 119) == 0) sw_hold = $urandom_range(1, 20);
      s = (sw_hold > 0);
      if (sw_hold > 0) sw_hold--;
      kk = ($urandom_range(0, 39) == 0);
      cycle(l, s, kk);
      if (i == 1500) do_reset();
    end
    $display("[TB] phase 6 random traffic done, %0d tests", tests_run);

`ifdef RST_WATCHDOG_EN
    // 7: watchdog fires 32 cycles after rst_done with no kicks; flag is sticky
    do_reset();
    for (int k = 1; k <= 130; k++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (k == 46 + WDT) begin
        check("wdt fire rst_out", seq_if.rst_out, 4'hF);
        check("wdt fire flag", seq_if.wdt_flag, 1);
      end
      if (k == 125) begin
        check("wdt re-release rst_out", seq_if.rst_out, 0);
        check("wdt sticky flag", seq_if.wdt_flag, 1);
      end
    end
    do_reset();
    $display("[TB] phase 7 watchdog done, %0d tests", tests_run);
`endif

    @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
